// File: rtl/mem_access_ctrl.sv
//-----------------------------------------------------------------------------
// mem_access_ctrl
// Converts core load/store requests (B/H/W, signed/unsigned loads) into
// word-aligned memory accesses with byte-lane enables. It returns one
// completion pulse per request, carrying extended load data or an error.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready core request handshake (ready only while idle)
//   req_we/op/addr/wdata request fields (op = funct3)
//   rsp_valid/rdata/err one-cycle completion pulse
//   mem_req/we/addr/be/wdata  memory request, held until mem_ack
//   mem_ack/mem_rdata   memory completion, read data valid with ack
//
// Build option: define MEM_ACCESS_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYCLES cycles in ACCESS without mem_ack (reported as rsp_err).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [DW-1:0]    mem_addr_q, mem_addr_d;
  logic [BEW-1:0]   mem_be_q, mem_be_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       off_q, off_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit_c;
  // Last allowed ACCESS cycle: no ack now means abort at this edge
  assign tmo_hit_c = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Request decode: legality, alignment, lane enables, replicated store data
  logic          req_bad_c;
  logic [BEW-1:0] req_be_c;
  logic [DW-1:0] req_wdata_c;

  always_comb begin
    req_bad_c = (req_op == 3'b011) || (req_op[2:1] == 2'b11) || (req_we && req_op[2]) ||
                ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                ((req_op[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    case (req_op[1:0])
      2'b00:   req_be_c = 4'b0001 << req_addr[1:0];
      2'b01:   req_be_c = req_addr[1] ? 4'b1100 : 4'b0011;
      default: req_be_c = 4'b1111;
    endcase
    req_wdata_c = '0;
    if (req_we) begin
      case (req_op[1:0])
        2'b00:   req_wdata_c = {4{req_wdata[7:0]}};
        2'b01:   req_wdata_c = {2{req_wdata[15:0]}};
        default: req_wdata_c = req_wdata;
      endcase
    end
  end

  // Load lane selection and extension from the returned word
  logic [7:0]    ld_byte_c;
  logic [15:0]   ld_half_c;
  logic [DW-1:0] ld_data_c;

  always_comb begin
    ld_byte_c = mem_rdata[8*off_q +: 8];
    ld_half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_data_c = {24'd0, ld_byte_c};
      3'b101:  ld_data_c = {16'd0, ld_half_c};
      default: ld_data_c = mem_rdata;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    op_d        = op_q;
    off_d       = off_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          off_d = req_addr[1:0];
          if (req_bad_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = req_be_c;
            mem_wdata_d = req_wdata_c;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end
        end
      end

      ST_ACCESS: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_we_q ? '0 : ld_data_c;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (tmo_hit_c) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
`endif
        // Memory side goes quiet as soon as the access ends
        if (state_d == ST_RESP) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      op_q        <= '0;
      off_q       <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      op_q        <= op_d;
      off_q       <= off_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
//-----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench: directed and randomized load/store transactions
// checked against a transaction-level model of lane/extension rules.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned op_size(input logic [2:0] op);
    case (op)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit is_ok(input logic we, input logic [2:0] op, input logic [31:0] addr);
    int unsigned sz = op_size(op);
    if (sz == 0) return 1'b0;
    if (we && op[2]) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] addr);
    int unsigned sz = op_size(op);
    return 4'(((1 << sz) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic we, input logic [2:0] op, input logic [31:0] wd);
    int unsigned sz = op_size(op);
    longint unsigned mask, r;
    if (!we) return 32'd0;
    mask = (64'd1 << (8 * sz)) - 1;
    r = 0;
    for (int i = 0; i < int'(4 / sz); i++) r |= (64'(wd) & mask) << (8 * sz * i);
    return 32'(r);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic we, input logic [2:0] op,
                                            input logic [31:0] addr, input logic [31:0] rd);
    int unsigned sz = op_size(op);
    longint unsigned mask, v;
    if (we) return 32'd0;
    if (sz == 4) return rd;
    mask = (64'd1 << (8 * sz)) - 1;
    v = (64'(rd) >> (8 * (addr % 4))) & mask;
    if (!op[2] && (((v >> (8 * sz - 1)) & 64'd1) != 0)) v |= ~mask;
    return 32'(v);
  endfunction

  // ---------------- transaction driver/checker ----------------
  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int unsigned delay);
    bit ok;
    ok = is_ok(we, op, addr);
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    check("rsp_idle", 32'(rsp_valid), 32'd0);
    check("memreq_idle", 32'(mem_req), 32'd0);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    if (!ok) begin
      check("err_memreq", 32'(mem_req), 32'd0);
      check("err_rspv", 32'(rsp_valid), 32'd1);
      check("err_rsperr", 32'(rsp_err), 32'd1);
      check("err_rdata", rsp_rdata, 32'd0);
      check("err_ready", 32'(req_ready), 32'd0);
      mem_ack = 1'($urandom_range(0, 1));
    end else begin
      for (int k = 0; k <= int'(delay); k++) begin
        check("acc_memreq", 32'(mem_req), 32'd1);
        check("acc_we", 32'(mem_we), 32'(we));
        check("acc_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("acc_be", 32'(mem_be), 32'(exp_be(op, addr)));
        check("acc_wdata", mem_wdata, exp_wdata(we, op, wdata));
        check("acc_ready", 32'(req_ready), 32'd0);
        check("acc_rspv", 32'(rsp_valid), 32'd0);
        if (k == int'(delay)) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        @(negedge clk);
      end
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'd0);
      check("rsp_rdata", rsp_rdata, exp_rdata(we, op, addr, rdata));
      check("rsp_memreq", 32'(mem_req), 32'd0);
      check("rsp_ready", 32'(req_ready), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = '0; req_addr = '0;
    req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_rsperr", 32'(rsp_err), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_memwe", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;

    // Directed vectors
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_0000, 2);   // LB
    run_txn(1'b0, 3'b101, 32'h0000_0202, 32'd0, 32'h8001_1234, 1);   // LHU
    run_txn(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 32'h1234_5678, 0); // SB
    run_txn(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0);           // LW misaligned
    run_txn(1'b0, 3'b011, 32'h0000_0000, 32'd0, 32'd0, 0);           // illegal op
    run_txn(1'b1, 3'b100, 32'h0000_0010, 32'h55, 32'd0, 0);          // store BU illegal
    run_txn(1'b1, 3'b001, 32'h0000_0012, 32'hBEEF_C0DE, 32'd0, 3);  // SH upper
    run_txn(1'b0, 3'b001, 32'h0000_0020, 32'd0, 32'h0000_8000, 0);   // LH sign
    run_txn(1'b1, 3'b010, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'd0, 1);   // SW top

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 3));
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Access that never gets acked: mem_req for 16 cycles, then error
    @(negedge clk);
    mem_ack = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b010; req_addr = 32'h40; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("tmo_memreq", 32'(mem_req), 32'd1);
      check("tmo_rspv", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    check("tmo_memreq_drop", 32'(mem_req), 32'd0);
    check("tmo_rspv", 32'(rsp_valid), 32'd1);
    check("tmo_err", 32'(rsp_err), 32'd1);
    check("tmo_rdata", rsp_rdata, 32'd0);
    mem_ack = 1'b1;  // late ack
    @(negedge clk);
    mem_ack = 1'b0;
    check("tmo_late_rspv", 32'(rsp_valid), 32'd0);
    check("tmo_late_memreq", 32'(mem_req), 32'd0);
    check("tmo_late_ready", 32'(req_ready), 32'd1);
`endif

    // Reset in the middle of an access: abandoned, no response
    @(negedge clk);
    mem_ack = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010; req_addr = 32'h80; req_wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_memreq", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_memreq", 32'(mem_req), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_be", 32'(mem_be), 32'd0);
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      check("post_rst_rspv", 32'(rsp_valid), 32'd0);
      check("post_rst_memreq", 32'(mem_req), 32'd0);
    end

    // Recovery after reset
    run_txn(1'b0, 3'b100, 32'h0000_0001, 32'd0, 32'h0000_F000, 1);   // LBU
    @(negedge clk);
    check("final_rspv", 32'(rsp_valid), 32'd0);
    check("final_ready", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
